// File: rtl/brc_arb_pkg.sv
// Shared types for the two-requester comparator arbiter: request/response payloads and default tag width.
package brc_arb_pkg;

    localparam int BRC_TAG_W = 4;

    typedef struct packed {
        logic [31:0]          a;
        logic [31:0]          b;
        logic                 is_signed;
        logic [BRC_TAG_W-1:0] tag;
    } cmp_req_t;

    typedef struct packed {
        logic                 less;
        logic                 equal;
        logic [BRC_TAG_W-1:0] tag;
    } cmp_rsp_t;

endpackage

// File: rtl/brc_arbiter_brc.sv
// Branch-style 32-bit comparator, purely combinational (latency 0, no flow control).
// i_br_un selects signed compare when 1.
module brc_arbiter_brc (
    input  logic [31:0] i_br_a,
    input  logic [31:0] i_br_b,
    input  logic        i_br_un,
    output logic        o_br_lt,
    output logic        o_br_eq
);

    assign o_br_lt = i_br_un ? ($signed(i_br_a) < $signed(i_br_b)) : (i_br_a < i_br_b);
    assign o_br_eq = (i_br_a == i_br_b);

endmodule

// File: rtl/brc_arbiter.sv
// Shares one comparator between two requesters; result registered per requester (latency 1), a stalled slot only blocks its own requester.
// BRC_ARB_FIXED_PRIO_EN: requester 0 always wins contention instead of round-robin.
module brc_arbiter
    import brc_arb_pkg::*;
#(
    parameter int TAG_W = BRC_TAG_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req0_valid,
    output logic             o_req0_ready,
    input  logic [31:0]      i_req0_a,
    input  logic [31:0]      i_req0_b,
    input  logic             i_req0_signed,
    input  logic [TAG_W-1:0] i_req0_tag,
    input  logic             i_req1_valid,
    output logic             o_req1_ready,
    input  logic [31:0]      i_req1_a,
    input  logic [31:0]      i_req1_b,
    input  logic             i_req1_signed,
    input  logic [TAG_W-1:0] i_req1_tag,
    output logic             o_rsp0_valid,
    input  logic             i_rsp0_ready,
    output logic             o_rsp0_less,
    output logic             o_rsp0_equal,
    output logic [TAG_W-1:0] o_rsp0_tag,
    output logic             o_rsp1_valid,
    input  logic             i_rsp1_ready,
    output logic             o_rsp1_less,
    output logic             o_rsp1_equal,
    output logic [TAG_W-1:0] o_rsp1_tag
);

    logic     elig0, elig1;
    logic     gnt0, gnt1;
    logic     rsp0_vld_q, rsp0_vld_d, rsp1_vld_q, rsp1_vld_d;
    cmp_rsp_t rsp0_q, rsp0_d, rsp1_q, rsp1_d;
    cmp_req_t req0_s, req1_s, sel_s;
    cmp_rsp_t new_rsp;
    logic     cmp_lt, cmp_eq;

    // A slot can be refilled on the same cycle its current result drains.
    assign elig0 = ~i_rst & i_req0_valid & (~rsp0_vld_q | i_rsp0_ready);
    assign elig1 = ~i_rst & i_req1_valid & (~rsp1_vld_q | i_rsp1_ready);

`ifdef BRC_ARB_FIXED_PRIO_EN
    assign gnt0 = elig0;
    assign gnt1 = elig1 & ~elig0;
`else
    logic last_q, last_d;

    // last_q holds the index of the most recent grant; the other side wins a tie.
    assign gnt0   = elig0 & (~elig1 | last_q);
    assign gnt1   = elig1 & ~gnt0;
    assign last_d = (gnt0 | gnt1) ? gnt1 : last_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign o_req0_ready = gnt0;
    assign o_req1_ready = gnt1;

    assign req0_s = '{a: i_req0_a, b: i_req0_b, is_signed: i_req0_signed,
                      tag: BRC_TAG_W'(i_req0_tag)};
    assign req1_s = '{a: i_req1_a, b: i_req1_b, is_signed: i_req1_signed,
                      tag: BRC_TAG_W'(i_req1_tag)};
    assign sel_s  = gnt1 ? req1_s : req0_s;

    brc_arbiter_brc u_brc (
        .i_br_a  (sel_s.a),
        .i_br_b  (sel_s.b),
        .i_br_un (sel_s.is_signed),
        .o_br_lt (cmp_lt),
        .o_br_eq (cmp_eq)
    );

    assign new_rsp = '{less: cmp_lt, equal: cmp_eq, tag: sel_s.tag};

    always_comb begin
        rsp0_vld_d = rsp0_vld_q;
        rsp0_d     = rsp0_q;
        rsp1_vld_d = rsp1_vld_q;
        rsp1_d     = rsp1_q;
        if (gnt0) begin
            rsp0_vld_d = 1'b1;
            rsp0_d     = new_rsp;
        end else if (i_rsp0_ready) begin
            rsp0_vld_d = 1'b0;
        end
        if (gnt1) begin
            rsp1_vld_d = 1'b1;
            rsp1_d     = new_rsp;
        end else if (i_rsp1_ready) begin
            rsp1_vld_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rsp0_vld_q <= 1'b0;
            rsp0_q     <= '0;
            rsp1_vld_q <= 1'b0;
            rsp1_q     <= '0;
        end else begin
            rsp0_vld_q <= rsp0_vld_d;
            rsp0_q     <= rsp0_d;
            rsp1_vld_q <= rsp1_vld_d;
            rsp1_q     <= rsp1_d;
        end
    end

    assign o_rsp0_valid = rsp0_vld_q;
    assign o_rsp0_less  = rsp0_q.less;
    assign o_rsp0_equal = rsp0_q.equal;
    assign o_rsp0_tag   = TAG_W'(rsp0_q.tag);
    assign o_rsp1_valid = rsp1_vld_q;
    assign o_rsp1_less  = rsp1_q.less;
    assign o_rsp1_equal = rsp1_q.equal;
    assign o_rsp1_tag   = TAG_W'(rsp1_q.tag);

endmodule

// File: tb/tb_brc_arbiter.sv
// Directed bench for brc_arbiter: reset, signed/unsigned/equal compares, contention, backpressure, mid-run reset.
module tb_brc_arbiter;

    localparam int TAG_W = 4;

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             i_req0_valid = 1'b0, i_req1_valid = 1'b0;
    logic             o_req0_ready, o_req1_ready;
    logic [31:0]      i_req0_a = '0, i_req0_b = '0, i_req1_a = '0, i_req1_b = '0;
    logic             i_req0_signed = 1'b0, i_req1_signed = 1'b0;
    logic [TAG_W-1:0] i_req0_tag = '0, i_req1_tag = '0;
    logic             o_rsp0_valid, o_rsp1_valid;
    logic             i_rsp0_ready = 1'b0, i_rsp1_ready = 1'b0;
    logic             o_rsp0_less, o_rsp0_equal, o_rsp1_less, o_rsp1_equal;
    logic [TAG_W-1:0] o_rsp0_tag, o_rsp1_tag;

    int n_chk  = 0;
    int n_pass = 0;

    brc_arbiter #(.TAG_W(TAG_W)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready),
        .i_req0_a(i_req0_a), .i_req0_b(i_req0_b),
        .i_req0_signed(i_req0_signed), .i_req0_tag(i_req0_tag),
        .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready),
        .i_req1_a(i_req1_a), .i_req1_b(i_req1_b),
        .i_req1_signed(i_req1_signed), .i_req1_tag(i_req1_tag),
        .o_rsp0_valid(o_rsp0_valid), .i_rsp0_ready(i_rsp0_ready),
        .o_rsp0_less(o_rsp0_less), .o_rsp0_equal(o_rsp0_equal), .o_rsp0_tag(o_rsp0_tag),
        .o_rsp1_valid(o_rsp1_valid), .i_rsp1_ready(i_rsp1_ready),
        .o_rsp1_less(o_rsp1_less), .o_rsp1_equal(o_rsp1_equal), .o_rsp1_tag(o_rsp1_tag)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen 1 unit later.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic rsp0_is(input string tag, input logic v, input logic l, input logic e,
                           input logic [TAG_W-1:0] t);
        check({tag, ".v"}, 64'(o_rsp0_valid), 64'(v));
        check({tag, ".lt"}, 64'(o_rsp0_less), 64'(l));
        check({tag, ".eq"}, 64'(o_rsp0_equal), 64'(e));
        check({tag, ".tag"}, 64'(o_rsp0_tag), 64'(t));
    endtask

    task automatic rsp1_is(input string tag, input logic v, input logic l, input logic e,
                           input logic [TAG_W-1:0] t);
        check({tag, ".v"}, 64'(o_rsp1_valid), 64'(v));
        check({tag, ".lt"}, 64'(o_rsp1_less), 64'(l));
        check({tag, ".eq"}, 64'(o_rsp1_equal), 64'(e));
        check({tag, ".tag"}, 64'(o_rsp1_tag), 64'(t));
    endtask

    initial begin
        logic exp_g0;

        // Reset with no requests, then with a request pending: no grant while in reset
        step(); #1;
        rsp0_is("rst_rsp0", 0, 0, 0, 0);
        rsp1_is("rst_rsp1", 0, 0, 0, 0);
        check("rst_rdy0", 64'(o_req0_ready), 64'd0);
        check("rst_rdy1", 64'(o_req1_ready), 64'd0);
        i_req0_valid = 1'b1; i_rsp0_ready = 1'b1;
        #1;
        check("rst_rdy0_req", 64'(o_req0_ready), 64'd0);
        i_req0_valid = 1'b0;
        step();
        i_rst = 1'b0;
        step();

        // Signed vs unsigned on the same operands
        i_req0_valid = 1'b1; i_req0_a = 32'hFFFF_FFFF; i_req0_b = 32'h1;
        i_req0_signed = 1'b1; i_req0_tag = 4'd3;
        #1 check("s_rdy0", 64'(o_req0_ready), 64'd1);
        step();
        rsp0_is("signed", 1, 1, 0, 4'd3);
        i_req0_signed = 1'b0; i_req0_tag = 4'd5;
        #1 check("u_rdy0", 64'(o_req0_ready), 64'd1);
        step();
        rsp0_is("unsigned", 1, 0, 0, 4'd5);
        i_req0_valid = 1'b0;
        step();
        check("drain0", 64'(o_rsp0_valid), 64'd0);

        // Equality on requester 1, both signedness modes
        i_rsp1_ready = 1'b1;
        i_req1_valid = 1'b1; i_req1_a = 32'h8000_0000; i_req1_b = 32'h8000_0000;
        i_req1_signed = 1'b1; i_req1_tag = 4'd9;
        #1 check("eq_rdy1", 64'(o_req1_ready), 64'd1);
        step();
        rsp1_is("eq_s", 1, 0, 1, 4'd9);
        i_req1_signed = 1'b0; i_req1_tag = 4'hA;
        step();
        rsp1_is("eq_u", 1, 0, 1, 4'hA);
        i_req1_valid = 1'b0;
        step();

        // Contention: last grant went to 1, so 0 wins first
        i_req0_valid = 1'b1; i_req0_a = 32'd1; i_req0_b = 32'd2; i_req0_tag = 4'd1;
        i_req1_valid = 1'b1; i_req1_a = 32'd7; i_req1_b = 32'd2; i_req1_tag = 4'd2;
        for (int i = 0; i < 6; i++) begin
`ifdef BRC_ARB_FIXED_PRIO_EN
            exp_g0 = 1'b1;
`else
            exp_g0 = (i % 2 == 0);
`endif
            #1;
            check($sformatf("cont%0d_rdy0", i), 64'(o_req0_ready), 64'(exp_g0));
            check($sformatf("cont%0d_rdy1", i), 64'(o_req1_ready), 64'(!exp_g0));
            step();
        end
        i_req0_valid = 1'b0; i_req1_valid = 1'b0;
        step();

        // Backpressure: rsp0 stalled must not block requester 1
        i_req0_valid = 1'b1; i_req0_a = 32'd1; i_req0_b = 32'd2; i_req0_tag = 4'd7;
        step();
        i_rsp0_ready = 1'b0;
        i_req0_a = 32'd9; i_req0_tag = 4'd8;
        i_req1_valid = 1'b1; i_rsp1_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bp%0d_rdy0", i), 64'(o_req0_ready), 64'd0);
            check($sformatf("bp%0d_rdy1", i), 64'(o_req1_ready), 64'd1);
            step();
            rsp0_is($sformatf("bp%0d_hold", i), 1, 1, 0, 4'd7);
            check($sformatf("bp%0d_rsp1v", i), 64'(o_rsp1_valid), 64'd1);
        end
        // Release: last grant was 1 so 0 wins; drain and refill in the same cycle
        i_rsp0_ready = 1'b1;
        #1 check("bp_rel_rdy0", 64'(o_req0_ready), 64'd1);
        step();
        rsp0_is("bp_refill", 1, 0, 0, 4'd8);
        i_req0_valid = 1'b0; i_req1_valid = 1'b0;
        step();

        // Reset while rsp1 holds a result
        i_rsp1_ready = 1'b0;
        i_req1_valid = 1'b1; i_req1_tag = 4'hC;
        step();
        i_req1_valid = 1'b0;
        check("mr_rsp1_pre", 64'(o_rsp1_valid), 64'd1);
        #1 i_rst = 1'b1;
        #1;
        rsp1_is("mr_async", 0, 0, 0, 0);
        step();
        i_rst = 1'b0;
        step();
        rsp1_is("mr_after", 0, 0, 0, 0);
        check("mr_rsp0", 64'(o_rsp0_valid), 64'd0);
        i_rsp0_ready = 1'b1; i_rsp1_ready = 1'b1;
        i_req0_valid = 1'b1; i_req1_valid = 1'b1;
        #1;
        check("mr_first_rdy0", 64'(o_req0_ready), 64'd1);
        check("mr_first_rdy1", 64'(o_req1_ready), 64'd0);
        i_req0_valid = 1'b0; i_req1_valid = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/brc_arbiter.md
BRC_ARBITER -- requirements
Module: brc_arbiter

Interface
REQ-001 SHALL have parameter TAG_W, default 4, the width of the requester tag that is carried through to the response.
REQ-002 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have, for N in {0,1}, port i_reqN_valid, input, 1 bit: requester N presents an operand pair.
REQ-005 SHALL have, for N in {0,1}, port o_reqN_ready, output, 1 bit: requester N is granted the comparator this cycle.
REQ-006 SHALL have, for N in {0,1}, ports i_reqN_a and i_reqN_b, input, 32 bits each: operands, compared as a versus b.
REQ-007 SHALL have, for N in {0,1}, port i_reqN_signed, input, 1 bit: 1 = signed compare, 0 = unsigned compare.
REQ-008 SHALL have, for N in {0,1}, port i_reqN_tag, input, TAG_W bits: opaque tag returned with the result.
REQ-009 SHALL have, for N in {0,1}, port o_rspN_valid, output, 1 bit: a result is held for requester N.
REQ-010 SHALL have, for N in {0,1}, port i_rspN_ready, input, 1 bit: requester N consumes its result.
REQ-011 SHALL have, for N in {0,1}, ports o_rspN_less, o_rspN_equal and o_rspN_tag, output, 1 / 1 / TAG_W bits: result flags and the echoed tag.

Function
REQ-012 SHALL define slot_freeN as (~o_rspN_valid | i_rspN_ready), and eligibleN as (i_reqN_valid & slot_freeN).
REQ-013 SHALL grant at most one requester per cycle, and only an eligible one; o_reqN_ready is 1 exactly when N is granted.
REQ-014 SHALL grant the only eligible requester when just one is eligible, and SHALL grant the requester opposite last_grant when both are eligible.
REQ-015 SHALL update last_grant only on a cycle with a grant; cycles with no grant leave it unchanged.
REQ-016 SHALL treat a request as transferred when i_reqN_valid & o_reqN_ready; the requester holds valid and data stable until transfer.
REQ-017 SHALL register the result on the transfer edge, with o_rspN_valid = 1 one cycle after transfer (latency 1).
REQ-018 SHALL set the result as follows:
- less = (signed ? $signed(a) < $signed(b) : a < b);
- equal = (a == b);
- tag = the request tag.
REQ-019 SHALL hold o_rspN_* stable while o_rspN_valid & ~i_rspN_ready.
REQ-020 SHALL clear o_rspN_valid after i_rspN_ready is accepted unless a new transfer for N occurs that cycle; on simultaneous drain and fill, the new result replaces the old and valid stays 1.
REQ-021 SHALL never let a full, stalled slot N block requester M: M is granted every cycle it is eligible.
REQ-022 SHALL derive o_reqN_ready combinationally from the valid and ready inputs only; o_rspN_valid SHALL NOT depend combinationally on any input.

Reset
REQ-023 SHALL, while i_rst = 1, force:
- o_rspN_valid, o_rspN_less, o_rspN_equal, o_rspN_tag = 0;
- last_grant = 1, so requester 0 wins the first contention.
REQ-024 SHALL discard unconsumed results on a reset mid-operation; no grant is issued while i_rst = 1.

Configuration
REQ-025 SHALL, when macro BRC_ARB_FIXED_PRIO_EN is defined, grant requester 0 whenever it is eligible, ignoring and not maintaining last_grant.
REQ-026 SHALL, when BRC_ARB_FIXED_PRIO_EN is undefined, use the round-robin rule of REQ-014 and REQ-015.

Structure
REQ-027 SHALL place TAG_W default, typedef cmp_req_t {a, b, signed, tag} and typedef cmp_rsp_t {less, equal, tag} in package brc_arb_pkg.
REQ-028 SHALL instantiate exactly one brc comparator, driven by a grant-selected operand mux; its i_br_un is driven by the selected signed bit (1 = signed).

Verification
REQ-029 SHALL cover reset: i_rst pulsed with no requests -> all o_rsp* = 0, both o_req*_ready = 0.
REQ-030 SHALL cover signed and unsigned compare on the same operands:
- req0 a=0xFFFFFFFF, b=0x00000001, signed=1, tag=3 -> next cycle rsp0 valid, less=1, equal=0, tag=3;
- same operands with signed=0 -> less=0.
REQ-031 SHALL cover equality: req1 a=b=0x80000000, either signedness -> less=0, equal=1.
REQ-032 SHALL cover contention: both requests valid continuously, rsp ready=1 ->
- grants 0,1,0,1... without the macro;
- grants 0,0,0... with BRC_ARB_FIXED_PRIO_EN.
REQ-033 SHALL cover backpressure: rsp0 valid with i_rsp0_ready=0 and both requesting -> o_req0_ready=0, req1 granted every cycle, rsp0 data unchanged.
REQ-034 SHALL cover reset mid-operation: i_rst asserted while rsp1 valid -> o_rsp1_valid falls without waiting for i_clk, and no stale result appears after release.
